hms_counter: RTL and testbench

HMS_COUNTER -- requirements
Module: hms_counter

---
 rtl/hms_counter_pkg.sv | 25 ++
 rtl/hms_counter_edge_pulse.sv | 19 +
 rtl/hms_counter.sv | 107 ++++++++++
 tb/tb_hms_counter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hms_counter_pkg.sv
// Shared clock constants and the 24h-to-12h hour helper.
// Used by hms_counter and the downstream date counter.
package hms_counter_pkg;

   localparam int TIME_W = 6;

   typedef logic [TIME_W-1:0] time_t;

   localparam time_t HH_MAX = 6'd23;
   localparam time_t MI_MAX = 6'd59;
   localparam time_t SS_MAX = 6'd59;

   localparam logic [3:0] SET_TIME_STATE = 4'd5;
   localparam logic [3:0] SET_DATE_STATE = 4'd6;

   // Midnight and noon both display as 12 on a 12-hour face.
   function automatic logic [4:0] to_hh12(input time_t h);
      logic [4:0] r;
      if (h == 6'd0 || h == 6'd12) r = 5'd12;
      else if (h > 6'd12) r = 5'(h - 6'd12);
      else r = 5'(h);
      return r;
   endfunction

endpackage

// File: rtl/hms_counter_edge_pulse.sv
// One-register rising-edge detector for a debounced level button.
// pulse is high for the single clk in which level goes 0 -> 1.
module edge_pulse (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev <= 1'b0;
      else       prev <= level;
   end

   assign pulse = level & ~prev;

endmodule

// File: rtl/hms_counter.sv
// Hour/minute/second time-of-day counter with a time-set mode.
// Optional 12-hour outputs hh12/pm are enabled by HMS_COUNTER_AMPM_EN.
module hms_counter
   import hms_counter_pkg::*;
#(
   parameter logic [3:0] SET_STATE      = SET_TIME_STATE,
   parameter logic       RUN_STATE_MASK = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_1hz,
   input  logic        b1,
   input  logic        b2,
   input  logic        b3,
   input  logic [3:0]  state,
   output logic [5:0]  hh,
   output logic [5:0]  mi,
   output logic [5:0]  ss,
`ifdef HMS_COUNTER_AMPM_EN
   output logic [4:0]  hh12,
   output logic        pm,
`endif
   output logic        oneday
);

   logic  e1, e2, e3;
   logic  armed;
   logic  set_mode;
   logic  run_en;
   time_t hh_d, mi_d, ss_d;
   logic  oneday_d;

   edge_pulse u_ep1 (.clk(clk), .reset(reset), .level(b1), .pulse(e1));
   edge_pulse u_ep2 (.clk(clk), .reset(reset), .level(b2), .pulse(e2));
   edge_pulse u_ep3 (.clk(clk), .reset(reset), .level(b3), .pulse(e3));

   // Low for the first edge after reset release so that clk's events are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) armed <= 1'b0;
      else       armed <= 1'b1;
   end

   assign set_mode = (state == SET_STATE);
   assign run_en   = !set_mode && RUN_STATE_MASK;

   always_comb begin
      hh_d     = hh;
      mi_d     = mi;
      ss_d     = ss;
      oneday_d = 1'b0;
      if (armed) begin
         if (set_mode) begin
            if (e1) hh_d = (hh >= HH_MAX) ? '0 : hh + 1'b1;
            if (e2) mi_d = (mi >= MI_MAX) ? '0 : mi + 1'b1;
            if (e3) ss_d = '0;
         end else if (run_en && tick_1hz) begin
            if (ss == SS_MAX) begin
               ss_d = '0;
               if (mi == MI_MAX) begin
                  mi_d = '0;
                  if (hh == HH_MAX) begin
                     hh_d     = '0;
                     oneday_d = 1'b1;
                  end else begin
                     hh_d = hh + 1'b1;
                  end
               end else begin
                  mi_d = mi + 1'b1;
               end
            end else begin
               ss_d = ss + 1'b1;
            end
         end
      end
      // Recover from any corrupted field.
      if (hh_d > HH_MAX) hh_d = '0;
      if (mi_d > MI_MAX) mi_d = '0;
      if (ss_d > SS_MAX) ss_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hh     <= '0;
         mi     <= '0;
         ss     <= '0;
         oneday <= 1'b0;
      end else begin
         hh     <= hh_d;
         mi     <= mi_d;
         ss     <= ss_d;
         oneday <= oneday_d;
      end
   end

`ifdef HMS_COUNTER_AMPM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hh12 <= 5'd12;
         pm   <= 1'b0;
      end else begin
         hh12 <= to_hh12(hh_d);
         pm   <= (hh_d >= 6'd12);
      end
   end
`endif

endmodule

// File: tb/tb_hms_counter.sv
// Directed + random bench for hms_counter against a seconds-of-day model.
// Build with HMS_COUNTER_AMPM_EN defined to also cover hh12/pm.
module tb_hms_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
   logic [3:0] state = 4'd0;
   logic [5:0] hh, mi, ss;
   logic       oneday;
`ifdef HMS_COUNTER_AMPM_EN
   logic [4:0] hh12;
   logic       pm;
`endif

   int checks = 0;
   int errors = 0;

   int secs = 0;
   bit skip = 1'b1;
   bit pb1 = 1'b0, pb2 = 1'b0, pb3 = 1'b0;
   bit exp_od = 1'b0;
   int od_count = 0;

   always #5 clk = ~clk;

   hms_counter dut (
      .clk(clk),
      .reset(reset),
      .tick_1hz(tick_1hz),
      .b1(b1),
      .b2(b2),
      .b3(b3),
      .state(state),
      .hh(hh),
      .mi(mi),
      .ss(ss),
`ifdef HMS_COUNTER_AMPM_EN
      .hh12(hh12),
      .pm(pm),
`endif
      .oneday(oneday)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      int h;
      h = secs / 3600;
      chk("hh", 32'(hh), 32'(h));
      chk("mi", 32'(mi), 32'((secs / 60) % 60));
      chk("ss", 32'(ss), 32'(secs % 60));
      chk("oneday", 32'(oneday), 32'(exp_od));
`ifdef HMS_COUNTER_AMPM_EN
      chk("hh12", 32'(hh12), 32'((h % 12 == 0) ? 12 : h % 12));
      chk("pm", 32'(pm), 32'(h >= 12));
`endif
   endtask

   // Advance the model by one clk using the inputs now driven, then compare.
   task automatic step();
      int h, m, s;
      exp_od = 1'b0;
      if (reset) begin
         secs = 0;
         pb1 = 0; pb2 = 0; pb3 = 0;
         skip = 1'b1;
      end else begin
         if (!skip) begin
            if (state == 4'd5) begin
               h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
               if (b1 && !pb1) h = (h + 1) % 24;
               if (b2 && !pb2) m = (m + 1) % 60;
               if (b3 && !pb3) s = 0;
               secs = h * 3600 + m * 60 + s;
            end else if (tick_1hz) begin
               if (secs == 86399) exp_od = 1'b1;
               secs = (secs + 1) % 86400;
            end
         end
         skip = 1'b0;
         pb1 = b1; pb2 = b2; pb3 = b3;
      end
      @(posedge clk);
      #1;
      if (oneday === 1'b1) od_count++;
      chk_all();
      tick_1hz = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1hz = 1'b1;
         step();
      end
   endtask

   task automatic press(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         b1 = (which == 1); b2 = (which == 2); b3 = (which == 3);
         step();
         b1 = 0; b2 = 0; b3 = 0;
         step();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      secs = 0; pb1 = 0; pb2 = 0; pb3 = 0; exp_od = 1'b0; skip = 1'b1;
      chk("async_hh", 32'(hh), 0);
      chk("async_mi", 32'(mi), 0);
      chk("async_ss", 32'(ss), 0);
      chk("async_od", 32'(oneday), 0);
      step();
      step();
      reset = 1'b0;
      tick_1hz = 1'b1;
      b1 = 1'b1;
      step();
      chk("release_ign", 32'(ss), 0);
      b1 = 1'b0;
      step();
   endtask

   initial begin
      int hstart;
      @(posedge clk);
      #1;
      do_reset();

      // 60 ticks from midnight with stray buttons outside set mode.
      state = 4'd0;
      od_count = 0;
      for (int i = 0; i < 60; i++) begin
         b1 = 1'($urandom_range(0, 1));
         b2 = 1'($urandom_range(0, 1));
         b3 = 1'($urandom_range(0, 1));
         tick_1hz = 1'b1;
         step();
         if ($urandom_range(0, 2) == 0) step();
      end
      b1 = 0; b2 = 0; b3 = 0;
      step();
      chk("min1_ss", 32'(ss), 0);
      chk("min1_mi", 32'(mi), 1);
      chk("min1_hh", 32'(hh), 0);
      chk("min1_od", 32'(od_count), 0);

      // Preload 23:59:58 and cross midnight.
      state = 4'd5;
      press(1, 23);
      press(2, 58);
      press(3, 1);
      state = 4'd0;
      ticks(58);
      chk("pre_ss", 32'(ss), 58);
      od_count = 0;
      ticks(1);
      chk("t59_ss", 32'(ss), 59);
      chk("t59_hh", 32'(hh), 23);
      ticks(1);
      chk("mid_hh", 32'(hh), 0);
      chk("mid_od", 32'(oneday), 1);
      step();
      chk("od_once", 32'(od_count), 1);

      // Held button gives one event; 24 presses wrap hh back.
      state = 4'd5;
      hstart = int'(hh);
      b1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick_1hz = 1'($urandom_range(0, 1));
         step();
      end
      b1 = 1'b0;
      step();
      chk("hold_once", 32'(hh), 32'((hstart + 1) % 24));
      press(1, 23);
      chk("wrap24", 32'(hh), 32'(hstart));

      // Ticks frozen in set mode, clear, then resume.
      state = 4'd0;
      ticks(30);
      chk("ss30", 32'(ss), 30);
      state = 4'd5;
      ticks(5);
      chk("set_hold", 32'(ss), 30);
      press(3, 1);
      chk("b3_clr", 32'(ss), 0);
      state = 4'd0;
      ticks(1);
      chk("resume", 32'(ss), 1);

      // Random mix of modes, ticks and buttons.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: state = 4'd5;
            1: state = 4'd6;
            default: state = 4'd0;
         endcase
         tick_1hz = ($urandom_range(0, 2) == 0);
         b1 = 1'($urandom_range(0, 1));
         b2 = 1'($urandom_range(0, 1));
         b3 = ($urandom_range(0, 5) == 0);
         step();
      end
      b1 = 0; b2 = 0; b3 = 0;

      // Reach 12:34:56, then reset mid-cycle.
      do_reset();
      state = 4'd5;
      press(1, 12);
      press(2, 34);
      state = 4'd0;
      ticks(56);
      chk("pre_rst_hh", 32'(hh), 12);
      chk("pre_rst_ss", 32'(ss), 56);
      #2;
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
